mxint8_block_packer: RTL and testbench
======================================

Name: mxint8_block_packer

Overview:
- Upstream feeder of the MXINT8 dot-product datapath.
- Accepts a serial stream of (element_a, element_b) pairs, one pair per beat, with per-block shared scales.
- Assembles BLOCK_SIZE-wide packed element vectors plus scales into one block. Presents that block to the dot-product stage over a valid/ready handshake.
- Double-buffered (fill buffer + output register) so a full-rate stream of one pair per cycle sustains without bubbles.

Parameters:
- BLOCK_SIZE, default `BLOCK_SIZE (32): elements per MX block.
- ELEM_W, default `MXINT8_ELEMENT_WIDTH (8): element width.
- SCALE_W, default `SCALE_WIDTH (8): E8M0 scale width.
- CNT_W, default $clog2(BLOCK_SIZE+1): width of element counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  packer can accept beat
- s_elem_a  in  ELEM_W  element of vector A (two's complement, 1.6 fixed point)
- s_elem_b  in  ELEM_W  element of vector B
- s_scale_a  in  SCALE_W  scale A; sampled on first beat of block only
- s_scale_b  in  SCALE_W  scale B; sampled on first beat of block only
- s_last  in  1  final beat of block
- m_valid  out  1  packed block valid
- m_ready  in  1  downstream accepts block
- m_scale_a  out  SCALE_W  block scale A
- m_scale_b  out  SCALE_W  block scale B
- m_elements_a  out  BLOCK_SIZE*ELEM_W  packed A; lane i at [i*ELEM_W +: ELEM_W]
- m_elements_b  out  BLOCK_SIZE*ELEM_W  packed B
- m_count  out  CNT_W  real (non-padded) elements in block, 1..BLOCK_SIZE
- m_len_err  out  1  block closed by count reaching BLOCK_SIZE without s_last on the final beat
- m_nan  out  1  scale NaN flag (see Optional Feature)

Behaviour:
- Beat transfer on s_valid && s_ready; block transfer on m_valid && m_ready.
- Fill-side FSM:
  - IDLE: no beats held. First beat → write lane 0, latch scales, cnt=1. Go to FILL, or to CLOSED if s_last or BLOCK_SIZE==1.
  - FILL: each beat writes lane cnt, cnt++. Close on s_last or when cnt reaches BLOCK_SIZE.
  - CLOSED: fill buffer complete, waiting for output register.
- Transfer fill→output occurs in a cycle when state==CLOSED and the output register is empty or m_ready is high. Output register then loads scales, elements, count and len_err. m_valid=1 from the next cycle.
- Fill state returns to IDLE in the same cycle as the transfer. If a beat also arrives that cycle, it becomes lane 0 of the next block (state→FILL).
- s_ready = (state!=CLOSED) || transfer_this_cycle. Combinational, with no dependence on s_valid.
- Latency: final beat → m_valid is 2 cycles when the output register is free.
- Padding: lanes with index >= cnt are driven 0 in m_elements_a/b. Stale fill-buffer data must never reach the outputs.
- s_scale_a/b are ignored on non-first beats.
- m_len_err=1 only if the block closed at cnt==BLOCK_SIZE with s_last=0 on that beat. s_last on the BLOCK_SIZE-th beat gives m_len_err=0.
- Output register holds stable while m_valid && !m_ready.
- Reset (synchronous, any state, including mid-block): state=IDLE, cnt=0, m_valid=0, s_ready=1 the cycle after reset deasserts.
  - All m_* data outputs reset to 0.
  - A partial block in progress is discarded; no output is produced for it.

Optional Feature:
- Macro MXINT8_PACK_NAN_SCALE_EN.
- Defined: m_nan=1 when latched m_scale_a or m_scale_b == all-ones (8'hFF, E8M0 NaN). Registered with the block.
- Undefined: m_nan tied 0 and no compare logic is generated.

Decomposition:
- Shared package mxint8_pkg holds:
  - typedef for the element type and the packed block type (elements[BLOCK_SIZE]).
  - typedef for the fill FSM enum {IDLE, FILL, CLOSED}.
  - localparam SCALE_NAN = '1.
- One sub-module, mxint8_block_outreg: the output register with valid/ready hold and zero-padding mask generation from count. The packer instantiates it once.

Test Plan:
- Full block: 32 beats, a[i]=i, b[i]=-i, scales 8'h7F/8'h80, s_last on beat 32. Required response:
  - One m_valid with lanes matching and m_count=32.
  - m_len_err=0, m_nan=0.
  - Latency of 2 cycles from the last beat.
- Short block: 5 beats, elements 8'h40, s_last on beat 5. Required response: m_count=5, lanes 0-4 = 8'h40, lanes 5-31 = 0. A previous block's stale data is not visible.
- Back-to-back with m_ready=1: three 32-beat blocks, s_valid continuous. Required response: s_ready never drops and there are exactly 3 output transfers, spaced 32 cycles apart.
- Backpressure: m_ready=0 while two full blocks stream in. Required response:
  - s_ready deasserts after the 64th beat; the first block is held stable.
  - m_ready=1 delivers blocks 1 then 2 unmodified.
- Missing s_last over 32 beats: m_len_err=1, m_count=32. The next beat starts a fresh block whose scales come from its own first beat.
- Reset asserted after beat 10 of a block: no output is produced. The next block's first beat lands in lane 0. With MXINT8_PACK_NAN_SCALE_EN, scale_a=8'hFF gives m_nan=1.

Source files
------------

// File: rtl/mxint8_pkg.sv
// +----------------------------------------------------------------------------
// | mxint8_pkg : shared types and constants for the MXINT8 block packer
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif
`ifndef MXINT8_ELEMENT_WIDTH
`define MXINT8_ELEMENT_WIDTH 8
`endif
`ifndef SCALE_WIDTH
`define SCALE_WIDTH 8
`endif

package mxint8_pkg;

   localparam int BLOCK_SIZE_DEF = `BLOCK_SIZE;
   localparam int ELEM_W_DEF     = `MXINT8_ELEMENT_WIDTH;
   localparam int SCALE_W_DEF    = `SCALE_WIDTH;

   typedef logic signed [ELEM_W_DEF-1:0] elem_t;
   typedef elem_t [BLOCK_SIZE_DEF-1:0]   elem_block_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      CLOSED = 2'd2
   } fill_state_t;

   // E8M0 encodes NaN as the all-ones exponent
   localparam logic [SCALE_W_DEF-1:0] SCALE_NAN = '1;

endpackage

`default_nettype wire

// File: rtl/mxint8_block_outreg.sv
// +----------------------------------------------------------------------------
// | mxint8_block_outreg : output block register with valid/ready hold and
// | zero-padding of lanes beyond count. Optional: MXINT8_PACK_NAN_SCALE_EN
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mxint8_block_outreg
   import mxint8_pkg::*;
#(
   parameter int BLOCK_SIZE = 32,
   parameter int ELEM_W     = 8,
   parameter int SCALE_W    = 8,
   parameter int CNT_W      = $clog2(BLOCK_SIZE + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load_i,
   input  logic [SCALE_W-1:0]           scale_a_i,
   input  logic [SCALE_W-1:0]           scale_b_i,
   input  logic [BLOCK_SIZE*ELEM_W-1:0] elems_a_i,
   input  logic [BLOCK_SIZE*ELEM_W-1:0] elems_b_i,
   input  logic [CNT_W-1:0]             count_i,
   input  logic                         len_err_i,
   input  logic                         ready_i,
   output logic                         valid_o,
   output logic [SCALE_W-1:0]           scale_a_o,
   output logic [SCALE_W-1:0]           scale_b_o,
   output logic [BLOCK_SIZE*ELEM_W-1:0] elems_a_o,
   output logic [BLOCK_SIZE*ELEM_W-1:0] elems_b_o,
   output logic [CNT_W-1:0]             count_o,
   output logic                         len_err_o,
   output logic                         nan_o
);

   logic [BLOCK_SIZE*ELEM_W-1:0] pad_mask;
   logic                         valid_q;
   logic [SCALE_W-1:0]           scale_a_q;
   logic [SCALE_W-1:0]           scale_b_q;
   logic [BLOCK_SIZE*ELEM_W-1:0] elems_a_q;
   logic [BLOCK_SIZE*ELEM_W-1:0] elems_b_q;
   logic [CNT_W-1:0]             count_q;
   logic                         len_err_q;

   // Fill-buffer lanes past the block length hold stale data; mask them off
   for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_mask
      assign pad_mask[i*ELEM_W +: ELEM_W] = {ELEM_W{CNT_W'(i) < count_i}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         scale_a_q <= '0;
         scale_b_q <= '0;
         elems_a_q <= '0;
         elems_b_q <= '0;
         count_q   <= '0;
         len_err_q <= 1'b0;
      end else if (load_i) begin
         valid_q   <= 1'b1;
         scale_a_q <= scale_a_i;
         scale_b_q <= scale_b_i;
         elems_a_q <= elems_a_i & pad_mask;
         elems_b_q <= elems_b_i & pad_mask;
         count_q   <= count_i;
         len_err_q <= len_err_i;
      end else if (ready_i) begin
         valid_q   <= 1'b0;
      end
   end

`ifdef MXINT8_PACK_NAN_SCALE_EN
   logic nan_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         nan_q <= 1'b0;
      end else if (load_i) begin
         nan_q <= (scale_a_i == SCALE_W'(SCALE_NAN)) || (scale_b_i == SCALE_W'(SCALE_NAN));
      end
   end

   assign nan_o = nan_q;
`else
   assign nan_o = 1'b0;
`endif

   assign valid_o   = valid_q;
   assign scale_a_o = scale_a_q;
   assign scale_b_o = scale_b_q;
   assign elems_a_o = elems_a_q;
   assign elems_b_o = elems_b_q;
   assign count_o   = count_q;
   assign len_err_o = len_err_q;

endmodule

`default_nettype wire

// File: rtl/mxint8_block_packer.sv
// +----------------------------------------------------------------------------
// | mxint8_block_packer : serial (a,b) beat stream to double-buffered MXINT8
// | block. Optional: MXINT8_PACK_NAN_SCALE_EN (m_nan on all-ones scale)
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif
`ifndef MXINT8_ELEMENT_WIDTH
`define MXINT8_ELEMENT_WIDTH 8
`endif
`ifndef SCALE_WIDTH
`define SCALE_WIDTH 8
`endif

module mxint8_block_packer
   import mxint8_pkg::*;
#(
   parameter int BLOCK_SIZE = `BLOCK_SIZE,
   parameter int ELEM_W     = `MXINT8_ELEMENT_WIDTH,
   parameter int SCALE_W    = `SCALE_WIDTH,
   parameter int CNT_W      = $clog2(BLOCK_SIZE + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [ELEM_W-1:0]            s_elem_a,
   input  logic [ELEM_W-1:0]            s_elem_b,
   input  logic [SCALE_W-1:0]           s_scale_a,
   input  logic [SCALE_W-1:0]           s_scale_b,
   input  logic                         s_last,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [SCALE_W-1:0]           m_scale_a,
   output logic [SCALE_W-1:0]           m_scale_b,
   output logic [BLOCK_SIZE*ELEM_W-1:0] m_elements_a,
   output logic [BLOCK_SIZE*ELEM_W-1:0] m_elements_b,
   output logic [CNT_W-1:0]             m_count,
   output logic                         m_len_err,
   output logic                         m_nan
);

   fill_state_t                  state_q;
   logic [CNT_W-1:0]             cnt_q;
   logic [CNT_W-1:0]             cnt_d;
   logic [CNT_W-1:0]             wr_idx;
   logic [SCALE_W-1:0]           scale_a_q;
   logic [SCALE_W-1:0]           scale_b_q;
   logic                         len_err_q;
   logic [ELEM_W-1:0]            fill_a_q [BLOCK_SIZE];
   logic [ELEM_W-1:0]            fill_b_q [BLOCK_SIZE];
   logic [BLOCK_SIZE*ELEM_W-1:0] fill_a_flat;
   logic [BLOCK_SIZE*ELEM_W-1:0] fill_b_flat;
   logic                         xfer;
   logic                         beat;
   logic                         first_beat;
   logic                         close_blk;

   assign xfer       = (state_q == CLOSED) && (!m_valid || m_ready);
   assign s_ready    = (state_q != CLOSED) || xfer;
   assign beat       = s_valid && s_ready;
   // A beat seen outside FILL opens a new block (CLOSED only accepts while draining)
   assign first_beat = (state_q != FILL);
   assign wr_idx     = first_beat ? '0 : cnt_q;
   assign cnt_d      = wr_idx + CNT_W'(1);
   assign close_blk  = s_last || (cnt_d == CNT_W'(BLOCK_SIZE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         scale_a_q <= '0;
         scale_b_q <= '0;
         len_err_q <= 1'b0;
      end else if (beat) begin
         cnt_q     <= cnt_d;
         len_err_q <= !s_last && (cnt_d == CNT_W'(BLOCK_SIZE));
         state_q   <= close_blk ? CLOSED : FILL;
         if (first_beat) begin
            scale_a_q <= s_scale_a;
            scale_b_q <= s_scale_b;
         end
      end else if (xfer) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
         if (beat && (wr_idx == CNT_W'(i))) begin
            fill_a_q[i] <= s_elem_a;
            fill_b_q[i] <= s_elem_b;
         end
      end
   end

   for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_flat
      assign fill_a_flat[i*ELEM_W +: ELEM_W] = fill_a_q[i];
      assign fill_b_flat[i*ELEM_W +: ELEM_W] = fill_b_q[i];
   end

   mxint8_block_outreg #(
      .BLOCK_SIZE (BLOCK_SIZE),
      .ELEM_W     (ELEM_W),
      .SCALE_W    (SCALE_W),
      .CNT_W      (CNT_W)
   ) u_outreg (
      .clk       (clk),
      .rst       (rst),
      .load_i    (xfer),
      .scale_a_i (scale_a_q),
      .scale_b_i (scale_b_q),
      .elems_a_i (fill_a_flat),
      .elems_b_i (fill_b_flat),
      .count_i   (cnt_q),
      .len_err_i (len_err_q),
      .ready_i   (m_ready),
      .valid_o   (m_valid),
      .scale_a_o (m_scale_a),
      .scale_b_o (m_scale_b),
      .elems_a_o (m_elements_a),
      .elems_b_o (m_elements_b),
      .count_o   (m_count),
      .len_err_o (m_len_err),
      .nan_o     (m_nan)
   );

endmodule

`default_nettype wire

// File: tb/tb_mxint8_block_packer.sv
// +----------------------------------------------------------------------------
// | tb_mxint8_block_packer : randomized bench with a queue-based block model
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_mxint8_block_packer;

   localparam int BS = 32;
   localparam int EW = 8;
   localparam int CW = 6;
   localparam int VW = BS * EW;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [7:0]    s_elem_a;
   logic [7:0]    s_elem_b;
   logic [7:0]    s_scale_a;
   logic [7:0]    s_scale_b;
   logic          s_last;
   logic          m_valid;
   logic          m_ready;
   logic [7:0]    m_scale_a;
   logic [7:0]    m_scale_b;
   logic [VW-1:0] m_elements_a;
   logic [VW-1:0] m_elements_b;
   logic [CW-1:0] m_count;
   logic          m_len_err;
   logic          m_nan;

   always #5 clk = ~clk;

   mxint8_block_packer dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_elem_a     (s_elem_a),
      .s_elem_b     (s_elem_b),
      .s_scale_a    (s_scale_a),
      .s_scale_b    (s_scale_b),
      .s_last       (s_last),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_scale_a    (m_scale_a),
      .m_scale_b    (m_scale_b),
      .m_elements_a (m_elements_a),
      .m_elements_b (m_elements_b),
      .m_count      (m_count),
      .m_len_err    (m_len_err),
      .m_nan        (m_nan)
   );

   typedef struct {
      logic [VW-1:0] a;
      logic [VW-1:0] b;
      logic [7:0]    sa;
      logic [7:0]    sb;
      int            cnt;
      logic          len_err;
      logic          nan;
   } blk_t;

   blk_t       exp_q[$];
   logic [7:0] pa [BS];
   logic [7:0] pb [BS];
   int         pcnt = 0;
   logic [7:0] psa, psb;
   int         n_vec = 0;
   int         n_err = 0;
   int         ncyc = 0;
   int         xfer_cyc[$];
   int         sready_drops = 0;
   int         ready_mode = 1;

   task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_nan(input logic [7:0] a, input logic [7:0] b);
`ifdef MXINT8_PACK_NAN_SCALE_EN
      return (a == 8'hFF) || (b == 8'hFF);
`else
      return 1'b0;
`endif
   endfunction

   // Reference: collect accepted beats, emit a block on s_last or a full block
   task automatic model_beat();
      blk_t blk;
      if (pcnt == 0) begin
         psa = s_scale_a;
         psb = s_scale_b;
      end
      pa[pcnt] = s_elem_a;
      pb[pcnt] = s_elem_b;
      pcnt++;
      if (s_last || pcnt == BS) begin
         blk.a = '0;
         blk.b = '0;
         for (int i = 0; i < pcnt; i++) begin
            blk.a[i*EW +: EW] = pa[i];
            blk.b[i*EW +: EW] = pb[i];
         end
         blk.sa      = psa;
         blk.sb      = psb;
         blk.cnt     = pcnt;
         blk.len_err = !s_last;
         blk.nan     = exp_nan(psa, psb);
         exp_q.push_back(blk);
         pcnt = 0;
      end
   endtask

   always @(negedge clk) begin
      ncyc++;
      if (rst) begin
         pcnt = 0;
         exp_q.delete();
      end else begin
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_m_valid", VW'(m_valid), '0);
            end else begin
               check_eq("scale_a",  VW'(m_scale_a), VW'(exp_q[0].sa));
               check_eq("scale_b",  VW'(m_scale_b), VW'(exp_q[0].sb));
               check_eq("elems_a",  m_elements_a, exp_q[0].a);
               check_eq("elems_b",  m_elements_b, exp_q[0].b);
               check_eq("count",    VW'(m_count), VW'(exp_q[0].cnt));
               check_eq("len_err",  VW'(m_len_err), VW'(exp_q[0].len_err));
               check_eq("nan",      VW'(m_nan), VW'(exp_q[0].nan));
               if (m_ready) begin
                  void'(exp_q.pop_front());
                  xfer_cyc.push_back(ncyc);
               end
            end
         end
         if (s_valid && !s_ready) sready_drops++;
         if (s_valid && s_ready) model_beat();
      end
   end

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] sa, input logic [7:0] sb, input logic last);
      int t;
      t = 0;
      s_valid   = 1'b1;
      s_elem_a  = a;
      s_elem_b  = b;
      s_scale_a = sa;
      s_scale_b = sb;
      s_last    = last;
      @(negedge clk);
      while (!s_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) check_eq("s_ready_timeout", VW'(s_ready), VW'(1));
      @(posedge clk);
      #1;
   endtask

   // mode 0: a=i b=-i, 1: both 8'h40, 2: random; hold keeps s_valid high at the end
   task automatic send_block(input int n, input bit last_final, input logic [7:0] sa,
                             input logic [7:0] sb, input int mode, input int gap_pct, input bit hold);
      logic [7:0] a, b, xa, xb;
      for (int i = 0; i < n; i++) begin
         if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         case (mode)
            0:       begin a = 8'(i);  b = 8'(-i);  end
            1:       begin a = 8'h40;  b = 8'h40;   end
            default: begin a = 8'($urandom); b = 8'($urandom); end
         endcase
         xa = (i == 0) ? sa : 8'($urandom);
         xb = (i == 0) ? sb : 8'($urandom);
         send_beat(a, b, xa, xb, last_final && (i == n - 1));
      end
      if (!hold) begin
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || m_valid) && t < 1000) begin
         @(posedge clk);
         #2;
         t++;
      end
      check_eq("drain", VW'(exp_q.size()), '0);
   endtask

   initial begin
      int k;
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [7:0] sa, sb;
      int n;
      bit lf;
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
      s_elem_a = '0; s_elem_b = '0; s_scale_a = '0; s_scale_b = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_m_valid", VW'(m_valid), '0);
      check_eq("rst_s_ready", VW'(s_ready), VW'(1));
      check_eq("rst_count",   VW'(m_count), '0);
      check_eq("rst_elems",   m_elements_a, '0);
      check_eq("rst_scale",   VW'(m_scale_a), '0);
      @(posedge clk);
      #1;

      // full block with index pattern and 2-cycle latency
      xfer_cyc.delete();
      send_block(32, 1'b1, 8'h7F, 8'h80, 0, 0, 1'b0);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!m_valid && k < 10);
      check_eq("latency", VW'(k), VW'(2));
      drain();
      check_eq("full_xfers", VW'(xfer_cyc.size()), VW'(1));

      // short block after a full one: padding must hide stale lanes
      send_block(5, 1'b1, 8'h11, 8'h22, 1, 0, 1'b0);
      drain();

      // back-to-back streaming with m_ready high
      xfer_cyc.delete();
      sready_drops = 0;
      send_block(32, 1'b1, 8'h01, 8'h02, 2, 0, 1'b1);
      send_block(32, 1'b1, 8'h03, 8'h04, 2, 0, 1'b1);
      send_block(32, 1'b1, 8'h05, 8'h06, 2, 0, 1'b0);
      drain();
      check_eq("b2b_sready_drops", VW'(sready_drops), '0);
      check_eq("b2b_xfers", VW'(xfer_cyc.size()), VW'(3));
      if (xfer_cyc.size() == 3) begin
         check_eq("b2b_space1", VW'(xfer_cyc[1] - xfer_cyc[0]), VW'(32));
         check_eq("b2b_space2", VW'(xfer_cyc[2] - xfer_cyc[1]), VW'(32));
      end

      // backpressure: two blocks held off, then released in order
      ready_mode = 0;
      @(posedge clk);
      #1;
      send_block(32, 1'b1, 8'h21, 8'h31, 2, 0, 1'b1);
      send_block(32, 1'b1, 8'h41, 8'h51, 2, 0, 1'b0);
      @(negedge clk);
      check_eq("bp_s_ready", VW'(s_ready), '0);
      check_eq("bp_m_valid", VW'(m_valid), VW'(1));
      repeat (6) @(posedge clk);
      #1;
      xfer_cyc.delete();
      ready_mode = 1;
      drain();
      check_eq("bp_xfers", VW'(xfer_cyc.size()), VW'(2));

      // missing s_last, then a fresh block with its own scales
      send_block(32, 1'b0, 8'h55, 8'h66, 2, 0, 1'b1);
      send_block(7, 1'b1, 8'h77, 8'h88, 2, 0, 1'b0);
      drain();

      // reset mid-block discards the partial block
      send_block(10, 1'b0, 8'h99, 8'hAA, 2, 0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_m_valid", VW'(m_valid), '0);
      check_eq("mid_rst_s_ready", VW'(s_ready), VW'(1));
      check_eq("mid_rst_elems",   m_elements_a, '0);
      check_eq("mid_rst_count",   VW'(m_count), '0);
      @(posedge clk);
      #1;
      send_block(6, 1'b1, 8'hFF, 8'h3C, 2, 0, 1'b0);
      drain();

      // random lengths, gaps, scales and downstream stalls
      ready_mode = 2;
      for (int j = 0; j < 25; j++) begin
         n  = int'($urandom_range(1, 32));
         lf = (n < 32) ? 1'b1 : 1'($urandom_range(0, 1));
         sa = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
         sb = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
         send_block(n, lf, sa, sb, 2, 20, 1'($urandom_range(0, 1)));
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      ready_mode = 1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
